// File: rtl/comm_cp_insert.sv
// Cyclic-prefix inserter: collects N-sample symbols into a ping-pong buffer and replays CP+body at DAC pace.
// Define COMM_CP_GUARD_EN to add GUARD mid-scale idle ticks after every symbol.
module comm_cp_insert #(
    parameter int unsigned N      = 64,
    parameter int unsigned CP_LEN = 16,
    parameter int unsigned DIV    = 1,
    parameter int unsigned GUARD  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in_valid,
    input  logic [5:0] in_i,
    input  logic [5:0] in_q,
    output logic       out_valid,
    output logic [5:0] out_i,
    output logic [5:0] out_q,
    output logic       sym_start,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int unsigned AW = $clog2(N);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [AW-1:0] IDX_LAST = AW'(N - 1);
    localparam logic [AW-1:0] IDX_CP   = AW'(N - CP_LEN);
    localparam logic [5:0]    MID      = 6'h20;

`ifdef COMM_CP_GUARD_EN
    localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD) : 1;
    typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY, S_GUARD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} state_t;
`endif

    logic [11:0]    r_mem [2*N];
    logic [CW-1:0]  r_div_cnt;
    logic [AW-1:0]  r_wr_idx;
    logic           r_wr_bank;
    logic           r_dropping;
    logic [1:0]     r_full;
    state_t         r_state;
    logic [AW-1:0]  r_rd_idx;
    logic           r_rd_bank;
`ifdef COMM_CP_GUARD_EN
    logic [GW-1:0]  r_gcnt;
    logic [GW-1:0]  w_gcnt_nxt;
`endif

    logic           w_tick;
    logic           w_release;
    logic [1:0]     w_rel_mask;
    logic [1:0]     w_set_mask;
    logic [1:0]     w_full_eff;
    logic           w_drop_start;
    logic           w_wr_en;
    logic           w_wr_done;
    logic [11:0]    w_rd_data;
    state_t         w_state_nxt;
    logic [AW-1:0]  w_rd_idx_nxt;
    logic           w_rd_bank_nxt;
    logic           w_o_valid;
    logic           w_o_sym;
    logic [5:0]     w_o_i;
    logic [5:0]     w_o_q;

    assign w_tick = (r_div_cnt == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == CW'(DIV - 1)) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

    // A bank released by the reader this very cycle counts as free for a new symbol start.
    assign w_rel_mask   = w_release ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_full_eff   = r_full & ~w_rel_mask;
    assign w_drop_start = in_valid && (r_wr_idx == '0) && !r_dropping && w_full_eff[r_wr_bank];
    assign w_wr_en      = in_valid && !w_drop_start && !r_dropping;
    assign w_wr_done    = w_wr_en && (r_wr_idx == IDX_LAST);
    assign w_set_mask   = w_wr_done ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[{r_wr_bank, r_wr_idx}] <= {in_i, in_q};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_idx   <= '0;
            r_wr_bank  <= 1'b0;
            r_dropping <= 1'b0;
            r_full     <= '0;
            overflow   <= 1'b0;
        end else begin
            if (in_valid) begin
                r_wr_idx <= r_wr_idx + AW'(1);
            end
            if (w_drop_start) begin
                r_dropping <= 1'b1;
            end else if (in_valid && r_dropping && (r_wr_idx == IDX_LAST)) begin
                r_dropping <= 1'b0;
            end
            if (w_wr_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
            r_full <= (r_full & ~w_rel_mask) | w_set_mask;
            if (w_drop_start) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign w_rd_data = r_mem[{r_rd_bank, r_rd_idx}];

    always_comb begin
        w_state_nxt   = r_state;
        w_rd_idx_nxt  = r_rd_idx;
        w_rd_bank_nxt = r_rd_bank;
        w_release     = 1'b0;
        w_o_valid     = 1'b0;
        w_o_sym       = 1'b0;
        w_o_i         = out_i;
        w_o_q         = out_q;
`ifdef COMM_CP_GUARD_EN
        w_gcnt_nxt    = r_gcnt;
`endif
        if (w_tick) begin
            w_o_i = MID;
            w_o_q = MID;
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        w_state_nxt  = S_CP;
                        w_rd_idx_nxt = IDX_CP;
                    end
                end
                S_CP: begin
                    w_o_valid = 1'b1;
                    w_o_sym   = (r_rd_idx == IDX_CP);
                    {w_o_i, w_o_q} = w_rd_data;
                    if (r_rd_idx == IDX_LAST) begin
                        w_state_nxt  = S_BODY;
                        w_rd_idx_nxt = '0;
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + AW'(1);
                    end
                end
                S_BODY: begin
                    w_o_valid = 1'b1;
                    {w_o_i, w_o_q} = w_rd_data;
                    if (r_rd_idx == IDX_LAST) begin
                        w_release     = 1'b1;
                        w_rd_bank_nxt = ~r_rd_bank;
`ifdef COMM_CP_GUARD_EN
                        w_state_nxt   = S_GUARD;
                        w_gcnt_nxt    = '0;
`else
                        if (r_full[~r_rd_bank]) begin
                            w_state_nxt  = S_CP;
                            w_rd_idx_nxt = IDX_CP;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
`endif
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + AW'(1);
                    end
                end
`ifdef COMM_CP_GUARD_EN
                S_GUARD: begin
                    if (r_gcnt == GW'(GUARD - 1)) begin
                        w_gcnt_nxt = '0;
                        if (r_full[r_rd_bank]) begin
                            w_state_nxt  = S_CP;
                            w_rd_idx_nxt = IDX_CP;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_gcnt_nxt = r_gcnt + GW'(1);
                    end
                end
`endif
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_rd_idx  <= '0;
            r_rd_bank <= 1'b0;
            out_valid <= 1'b0;
            sym_start <= 1'b0;
            out_i     <= MID;
            out_q     <= MID;
`ifdef COMM_CP_GUARD_EN
            r_gcnt    <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_rd_idx  <= w_rd_idx_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            out_valid <= w_o_valid;
            sym_start <= w_o_sym;
            out_i     <= w_o_i;
            out_q     <= w_o_q;
`ifdef COMM_CP_GUARD_EN
            r_gcnt    <= w_gcnt_nxt;
`endif
        end
    end

endmodule
